// File: rtl/fc_layer_tiled.sv
// fc_layer_tiled: fully-connected layer, OUT_SIZE neurons over an IN_SIZE input vector.
// Neurons are processed in groups of NUM_PE parallel MAC lanes. Each group takes IN_SIZE
// MAC cycles plus one post-processing cycle. Post-processing adds the bias, applies an
// arithmetic (floor) right shift by SHIFT, applies an optional ReLU and saturates to W bits.
// The output register is updated in one step once every group has finished.
//
// Ports:
//   clk             rising-edge clock
//   reset           synchronous, active-high
//   start           single-cycle request, only sampled while idle
//   relu_en         1 = ReLU applied, 0 = signed linear output (latched at start)
//   in_vector_flat  signed inputs, element k at [k*W +: W] (latched at start)
//   weights_flat    weight (n,k) at [(n*IN_SIZE+k)*W +: W]; must stay stable while busy
//   biases_flat     bias n at [n*W +: W]; must stay stable while busy
//   out_vector_flat signed results, neuron n at [n*W +: W]
//   busy            high while a computation is in progress
//   done            one-cycle pulse when out_vector_flat is updated
module fc_layer_tiled #(
    parameter int IN_SIZE   = 64,
    parameter int OUT_SIZE  = 8,
    parameter int NUM_PE    = 2,
    parameter int W         = 8,
    parameter int ACC_WIDTH = 2 * W + $clog2(IN_SIZE) + 1,
    parameter int SHIFT     = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           relu_en,
    input  logic [W*IN_SIZE-1:0]           in_vector_flat,
    input  logic [W*OUT_SIZE*IN_SIZE-1:0]  weights_flat,
    input  logic [W*OUT_SIZE-1:0]          biases_flat,
    output logic [W*OUT_SIZE-1:0]          out_vector_flat,
    output logic                           busy,
    output logic                           done
);

    localparam int G  = OUT_SIZE / NUM_PE;
    localparam int KW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    // One spare bit so the bias add can never wrap.
    localparam int SW = ACC_WIDTH + 1;

    localparam logic signed [SW-1:0] MAXV = {{(SW - W + 1){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = {{(SW - W + 1){1'b1}}, {(W - 1){1'b0}}};

    if ((OUT_SIZE % NUM_PE) != 0) begin : g_bad_cfg
        $error("fc_layer_tiled: OUT_SIZE must be a multiple of NUM_PE");
    end

    typedef enum logic [1:0] {StIdle, StMac, StPost, StDone} state_e;

    state_e                        state_q, state_d;
    logic [KW-1:0]                 k_q;
    logic [GW-1:0]                 g_q;
    logic [W*IN_SIZE-1:0]          in_q;
    logic                          relu_q;
    logic signed [ACC_WIDTH-1:0]   acc_q [NUM_PE];
    logic [W*OUT_SIZE-1:0]         res_q;
    logic [W*OUT_SIZE-1:0]         out_q;
    logic                          busy_q;
    logic                          done_q;

    logic                          last_k;
    logic                          last_g;

    logic signed [W-1:0]           x_sel;
    logic signed [W-1:0]           w_sel    [NUM_PE];
    logic signed [W-1:0]           b_sel    [NUM_PE];
    logic signed [2*W-1:0]         prod     [NUM_PE];
    logic signed [SW-1:0]          post_sum [NUM_PE];
    logic signed [SW-1:0]          post_rl  [NUM_PE];
    logic signed [W-1:0]           post_sat [NUM_PE];

    assign last_k = (k_q == KW'(IN_SIZE - 1));
    assign last_g = (g_q == GW'(G - 1));

    // ---------------------------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StMac;
            StMac:   if (last_k) state_d = StPost;
            StPost:  state_d = last_g ? StDone : StMac;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // ---------------------------------------------------------------------------------------
    // Lane datapath: products for the MAC phase and the post-processed result per lane
    // ---------------------------------------------------------------------------------------
    always_comb begin
        x_sel = in_q[int'(k_q) * W +: W];
        for (int l = 0; l < NUM_PE; l++) begin
            w_sel[l] = weights_flat[((int'(g_q) * NUM_PE + l) * IN_SIZE + int'(k_q)) * W +: W];
            b_sel[l] = biases_flat[(int'(g_q) * NUM_PE + l) * W +: W];
            prod[l]  = x_sel * w_sel[l];

            post_sum[l] = (SW'(acc_q[l]) + SW'(b_sel[l])) >>> SHIFT;

            if (relu_q && post_sum[l][SW-1]) begin
                post_rl[l] = '0;
            end else begin
                post_rl[l] = post_sum[l];
            end

            if (post_rl[l] > MAXV) begin
                post_sat[l] = MAXV[W-1:0];
            end else if (post_rl[l] < MINV) begin
                post_sat[l] = MINV[W-1:0];
            end else begin
                post_sat[l] = post_rl[l][W-1:0];
            end
        end
    end

    // ---------------------------------------------------------------------------------------
    // State-dependent registers
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            k_q    <= '0;
            g_q    <= '0;
            in_q   <= '0;
            relu_q <= 1'b0;
            res_q  <= '0;
            out_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            for (int l = 0; l < NUM_PE; l++) begin
                acc_q[l] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        in_q   <= in_vector_flat;
                        relu_q <= relu_en;
                        k_q    <= '0;
                        g_q    <= '0;
                        busy_q <= 1'b1;
                        for (int l = 0; l < NUM_PE; l++) begin
                            acc_q[l] <= '0;
                        end
                    end
                end
                StMac: begin
                    for (int l = 0; l < NUM_PE; l++) begin
                        acc_q[l] <= acc_q[l] + ACC_WIDTH'(prod[l]);
                    end
                    k_q <= last_k ? '0 : k_q + 1'b1;
                end
                StPost: begin
                    for (int l = 0; l < NUM_PE; l++) begin
                        res_q[(int'(g_q) * NUM_PE + l) * W +: W] <= post_sat[l];
                        acc_q[l] <= '0;
                    end
                    k_q <= '0;
                    if (!last_g) begin
                        g_q <= g_q + 1'b1;
                    end
                end
                StDone: begin
                    // Publish every group at once so the output never shows a partial result.
                    out_q  <= res_q;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign out_vector_flat = out_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_fc_layer_tiled.sv
// Self-checking bench for fc_layer_tiled with IN_SIZE=4, OUT_SIZE=4, W=8.
// Instances: 0 = NUM_PE 2 / SHIFT 0, 1 = NUM_PE 2 / SHIFT 4, 2 = NUM_PE 4, 3 = NUM_PE 1.
module tb_fc_layer_tiled;

    logic        clk;
    logic        reset;
    logic [3:0]  starts;
    logic        relu_en;
    logic [31:0] in_vec;
    logic [127:0] weights;
    logic [31:0] biases;
    logic [31:0] outs [4];
    logic [3:0]  busys;
    logic [3:0]  dones;

    int total;
    int bad;

    fc_layer_tiled #(.IN_SIZE(4), .OUT_SIZE(4), .NUM_PE(2), .W(8), .SHIFT(0)) dut0 (
        .clk(clk), .reset(reset), .start(starts[0]), .relu_en(relu_en),
        .in_vector_flat(in_vec), .weights_flat(weights), .biases_flat(biases),
        .out_vector_flat(outs[0]), .busy(busys[0]), .done(dones[0])
    );
    fc_layer_tiled #(.IN_SIZE(4), .OUT_SIZE(4), .NUM_PE(2), .W(8), .SHIFT(4)) dut1 (
        .clk(clk), .reset(reset), .start(starts[1]), .relu_en(relu_en),
        .in_vector_flat(in_vec), .weights_flat(weights), .biases_flat(biases),
        .out_vector_flat(outs[1]), .busy(busys[1]), .done(dones[1])
    );
    fc_layer_tiled #(.IN_SIZE(4), .OUT_SIZE(4), .NUM_PE(4), .W(8), .SHIFT(0)) dut2 (
        .clk(clk), .reset(reset), .start(starts[2]), .relu_en(relu_en),
        .in_vector_flat(in_vec), .weights_flat(weights), .biases_flat(biases),
        .out_vector_flat(outs[2]), .busy(busys[2]), .done(dones[2])
    );
    fc_layer_tiled #(.IN_SIZE(4), .OUT_SIZE(4), .NUM_PE(1), .W(8), .SHIFT(0)) dut3 (
        .clk(clk), .reset(reset), .start(starts[3]), .relu_en(relu_en),
        .in_vector_flat(in_vec), .weights_flat(weights), .biases_flat(biases),
        .out_vector_flat(outs[3]), .busy(busys[3]), .done(dones[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Uniform data, or (rows=1) case-1 style weights where row n is all n+1.
    task automatic load(input logic [7:0] x, input logic [7:0] wv, input logic [7:0] b,
                        input bit rows);
        for (int k = 0; k < 4; k++) in_vec[k*8 +: 8] = x;
        for (int n = 0; n < 4; n++) begin
            biases[n*8 +: 8] = b;
            for (int k = 0; k < 4; k++) weights[(n*4 + k)*8 +: 8] = rows ? 8'(n + 1) : wv;
        end
    endtask

    // Pulses start on instance i (edge 0) and watches `cycles` further edges.
    // Optional start re-pulse at edges rep_a/rep_b and reset at edge rst_e (0 = none).
    task automatic run(input int i, input int rep_a, input int rep_b, input int rst_e,
                       input int cycles, output int done_e, output int done_n,
                       output int busy_n, output logic [31:0] mid_out, output logic mid_busy);
        mid_out  = '0;
        mid_busy = 1'b0;
        starts[i] = 1'b1;
        @(posedge clk); #1;
        starts[i] = 1'b0;
        done_e = -1;
        done_n = 0;
        busy_n = busys[i] ? 1 : 0;
        for (int e = 1; e <= cycles; e++) begin
            starts[i] = (e == rep_a) || (e == rep_b);
            reset     = (e == rst_e);
            @(posedge clk); #1;
            starts[i] = 1'b0;
            reset     = 1'b0;
            if (busys[i]) busy_n++;
            if (dones[i]) begin
                done_n++;
                if (done_e < 0) done_e = e;
            end
            if (e == 5) begin
                mid_out  = outs[i];
                mid_busy = busys[i];
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (outs[i] !== 32'h0) begin
                bad++;
                $display("FAIL reset_out[%0d]: got %h want 00000000", i, outs[i]);
            end
        end
        total++;
        if (busys !== 4'h0 || dones !== 4'h0) begin
            bad++;
            $display("FAIL reset_flags: busy=%b done=%b want 0000/0000", busys, dones);
        end
    endtask

    task automatic test_basic();
        int de, dn, bn;
        logic [31:0] mo;
        logic mb;
        load(8'd1, 8'd0, 8'd0, 1'b1);
        relu_en = 1'b1;
        run(0, 0, 0, 0, 20, de, dn, bn, mo, mb);
        total++;
        if (outs[0] !== 32'h100C0804) begin
            bad++; $display("FAIL basic_out: got %h want 100c0804", outs[0]);
        end
        total++;
        if (de !== 11) begin bad++; $display("FAIL basic_done_edge: got %0d want 11", de); end
        total++;
        if (dn !== 1) begin bad++; $display("FAIL basic_done_count: got %0d want 1", dn); end
        total++;
        if (bn !== 11) begin bad++; $display("FAIL basic_busy_cycles: got %0d want 11", bn); end
    endtask

    task automatic test_relu();
        int de, dn, bn;
        logic [31:0] mo;
        logic mb;
        load(8'd1, 8'hF6, 8'd5, 1'b0);
        relu_en = 1'b1;
        run(0, 0, 0, 0, 14, de, dn, bn, mo, mb);
        total++;
        if (outs[0] !== 32'h00000000) begin
            bad++; $display("FAIL relu_on: got %h want 00000000", outs[0]);
        end
        relu_en = 1'b0;
        run(0, 0, 0, 0, 14, de, dn, bn, mo, mb);
        total++;
        if (outs[0] !== 32'hDDDDDDDD) begin
            bad++; $display("FAIL relu_off: got %h want dddddddd", outs[0]);
        end
    endtask

    task automatic test_saturate();
        int de, dn, bn;
        logic [31:0] mo;
        logic mb;
        load(8'd127, 8'd127, 8'd0, 1'b0);
        relu_en = 1'b1;
        run(0, 0, 0, 0, 14, de, dn, bn, mo, mb);
        total++;
        if (outs[0] !== 32'h7F7F7F7F) begin
            bad++; $display("FAIL sat_pos: got %h want 7f7f7f7f", outs[0]);
        end
        load(8'h80, 8'd127, 8'd0, 1'b0);
        relu_en = 1'b0;
        run(0, 0, 0, 0, 14, de, dn, bn, mo, mb);
        total++;
        if (outs[0] !== 32'h80808080) begin
            bad++; $display("FAIL sat_neg: got %h want 80808080", outs[0]);
        end
    endtask

    task automatic test_shift();
        int de, dn, bn;
        logic [31:0] mo;
        logic mb;
        load(8'd3, 8'd5, 8'd2, 1'b0);
        relu_en = 1'b1;
        run(1, 0, 0, 0, 14, de, dn, bn, mo, mb);
        total++;
        if (outs[1] !== 32'h03030303) begin
            bad++; $display("FAIL shift_pos: got %h want 03030303", outs[1]);
        end
        total++;
        if (de !== 11) begin bad++; $display("FAIL shift_done_edge: got %0d want 11", de); end
        load(8'd3, 8'hFB, 8'hFE, 1'b0);
        relu_en = 1'b0;
        run(1, 0, 0, 0, 14, de, dn, bn, mo, mb);
        total++;
        if (outs[1] !== 32'hFCFCFCFC) begin
            bad++; $display("FAIL shift_floor: got %h want fcfcfcfc", outs[1]);
        end
    endtask

    task automatic test_ignore_start();
        int de, dn, bn;
        logic [31:0] mo;
        logic mb;
        // Previous dut0 result is 80808080 from the saturation test.
        load(8'd1, 8'd0, 8'd0, 1'b1);
        relu_en = 1'b1;
        run(0, 3, 7, 0, 25, de, dn, bn, mo, mb);
        total++;
        if (mo !== 32'h80808080 || mb !== 1'b1) begin
            bad++; $display("FAIL hold_mid_run: got out=%h busy=%b want 80808080/1", mo, mb);
        end
        total++;
        if (dn !== 1 || de !== 11) begin
            bad++; $display("FAIL ignore_start: got done_count=%0d edge=%0d want 1/11", dn, de);
        end
        total++;
        if (bn !== 11) begin bad++; $display("FAIL ignore_busy: got %0d want 11", bn); end
        total++;
        if (outs[0] !== 32'h100C0804) begin
            bad++; $display("FAIL ignore_out: got %h want 100c0804", outs[0]);
        end
    endtask

    task automatic test_reset_mid();
        int de, dn, bn;
        logic [31:0] mo;
        logic mb;
        load(8'd1, 8'd0, 8'd0, 1'b1);
        relu_en = 1'b1;
        run(0, 0, 0, 5, 25, de, dn, bn, mo, mb);
        total++;
        if (mo !== 32'h0 || mb !== 1'b0) begin
            bad++; $display("FAIL reset_mid_state: got out=%h busy=%b want 00000000/0", mo, mb);
        end
        total++;
        if (dn !== 0) begin bad++; $display("FAIL reset_mid_done: got %0d want 0", dn); end
        run(0, 0, 0, 0, 14, de, dn, bn, mo, mb);
        total++;
        if (outs[0] !== 32'h100C0804 || de !== 11) begin
            bad++;
            $display("FAIL reset_fresh: got out=%h edge=%0d want 100c0804/11", outs[0], de);
        end
    endtask

    task automatic test_back_to_back();
        int d1, d2, dn;
        logic [31:0] o1;
        o1 = '0;
        d1 = -1;
        d2 = -1;
        dn = 0;
        load(8'd1, 8'hF6, 8'd5, 1'b0);
        relu_en = 1'b0;
        starts[0] = 1'b1;
        @(posedge clk); #1;
        starts[0] = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            // Restart on the edge where done falls, with new data.
            if (d1 > 0 && e == d1 + 1) begin
                starts[0] = 1'b1;
                load(8'd1, 8'd0, 8'd0, 1'b1);
                relu_en = 1'b1;
            end
            @(posedge clk); #1;
            starts[0] = 1'b0;
            if (dones[0]) begin
                dn++;
                if (d1 < 0) begin
                    d1 = e;
                    o1 = outs[0];
                end else if (d2 < 0) begin
                    d2 = e;
                end
            end
        end
        total++;
        if (o1 !== 32'hDDDDDDDD || d1 !== 11) begin
            bad++; $display("FAIL b2b_first: got out=%h edge=%0d want dddddddd/11", o1, d1);
        end
        total++;
        if (d2 !== 23 || dn !== 2) begin
            bad++; $display("FAIL b2b_second_timing: got edge=%0d count=%0d want 23/2", d2, dn);
        end
        total++;
        if (outs[0] !== 32'h100C0804) begin
            bad++; $display("FAIL b2b_second_out: got %h want 100c0804", outs[0]);
        end
    endtask

    task automatic test_num_pe();
        int de, dn, bn;
        logic [31:0] mo;
        logic mb;
        load(8'd1, 8'd0, 8'd0, 1'b1);
        relu_en = 1'b1;
        run(2, 0, 0, 0, 12, de, dn, bn, mo, mb);
        total++;
        if (outs[2] !== 32'h100C0804 || de !== 6 || bn !== 6) begin
            bad++;
            $display("FAIL pe4: got out=%h edge=%0d busy=%0d want 100c0804/6/6", outs[2], de, bn);
        end
        run(3, 0, 0, 0, 28, de, dn, bn, mo, mb);
        total++;
        if (outs[3] !== 32'h100C0804 || de !== 21 || bn !== 21) begin
            bad++;
            $display("FAIL pe1: got out=%h edge=%0d busy=%0d want 100c0804/21/21", outs[3], de, bn);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        starts  = 4'h0;
        relu_en = 1'b1;
        in_vec  = '0;
        weights = '0;
        biases  = '0;
        test_reset();
        test_basic();
        test_relu();
        test_saturate();
        test_shift();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_num_pe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
